alu_arbiter: RTL and testbench

- Shares the single 8-bit combinational ALU between two requesters: port 0 is the execute stage, port 1 is the branch/compare unit.
- Arbitrates round-robin, registers the selected operands, drives the ALU, and returns a registered result.
- Owns the architectural overflow/carry flag (OverflowIn/OverflowOut) and the sticky halt state.
- Sits between the requesters and the ALU instance in the processor top level.

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 38 +++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcodes and arbiter FSM encodings.
// Used by the ALU decoder, the arbiter and the bench.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b0011;
  localparam logic [3:0] OP_MOV   = 4'b0100;
  localparam logic [3:0] OP_CPY   = 4'b0101;
  localparam logic [3:0] OP_NAND  = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_RST   = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1011;
  localparam logic [3:0] OP_LUT   = 4'b1100;
  localparam logic [3:0] OP_LT    = 4'b1101;
  localparam logic [3:0] OP_EQL   = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; pointer flips away from
// the requester that was just served.
module rr_arbiter2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic upd_id_i,
  output logic valid_o,
  output logic sel_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    valid_o = req0_i | req1_i;
    sel_o   = 1'b0;
    unique case (1'b1)
      (req0_i & req1_i):  sel_o = ptr_q;
      (req1_i & ~req0_i): sel_o = 1'b1;
      default:            sel_o = 1'b0;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = ~upd_id_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= RR_INIT;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between execute (port 0) and
// branch/compare (port 1); owns carry and halt state.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [7:0] OpA0,
  input  logic [7:0] OpA1,
  input  logic [7:0] OpB0,
  input  logic [7:0] OpB1,
  input  logic [3:0] Op0,
  input  logic [3:0] Op1,
  output logic       Gnt0,
  output logic       Gnt1,
  output logic       RspValid0,
  output logic       RspValid1,
  output logic [7:0] Result,
  output logic [7:0] AluA,
  output logic [7:0] AluB,
  output logic [3:0] AluOp,
  output logic       AluOvIn,
  input  logic [7:0] AluOut,
  input  logic       AluOvOut,
  output logic       Carry,
  output logic       Halted
);

  state_e     state_q, state_d;
  logic       id_q, id_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] op_q, op_d;
  logic [7:0] res_q, res_d;
  logic       carry_q, carry_d;
  logic [1:0] rsp_q, rsp_d;
  logic       arb_valid, arb_sel, upd;

  rr_arbiter2 #(
    .RR_INIT (RR_INIT)
  ) u_rr (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .req0_i   (Req0),
    .req1_i   (Req1),
    .upd_i    (upd),
    .upd_id_i (id_q),
    .valid_o  (arb_valid),
    .sel_o    (arb_sel)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    carry_d = carry_q;
    rsp_d   = 2'b00;
    upd     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          id_d    = arb_sel;
          a_d     = arb_sel ? OpA1 : OpA0;
          b_d     = arb_sel ? OpB1 : OpB0;
          op_d    = arb_sel ? Op1 : Op0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d        = AluOut;
        upd          = 1'b1;
        rsp_d[id_q]  = 1'b1;
        // Only add writes the flag; rst clears it.
        if (op_q == OP_ADD)      carry_d = AluOvOut;
        else if (op_q == OP_RST) carry_d = 1'b0;
        state_d = (op_q == OP_HALT) ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      rsp_q   <= rsp_d;
    end
  end

  assign Gnt0      = (state_q == ST_EXEC) & ~id_q;
  assign Gnt1      = (state_q == ST_EXEC) & id_q;
  assign RspValid0 = rsp_q[0];
  assign RspValid1 = rsp_q[1];
  assign Result    = res_q;
  assign AluA      = a_q;
  assign AluB      = b_q;
  assign AluOp     = op_q;
  assign AluOvIn   = carry_q;
  assign Carry     = carry_q;
  assign Halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural
// 8-bit ALU closing the loop.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Req0, Req1;
  logic [7:0] OpA0, OpA1, OpB0, OpB1;
  logic [3:0] Op0, Op1;
  logic       Gnt0, Gnt1, RspValid0, RspValid1;
  logic [7:0] Result, AluA, AluB;
  logic [3:0] AluOp;
  logic       AluOvIn;
  logic [7:0] AluOut;
  logic       AluOvOut;
  logic       Carry, Halted;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Req0      (Req0),
    .Req1      (Req1),
    .OpA0      (OpA0),
    .OpA1      (OpA1),
    .OpB0      (OpB0),
    .OpB1      (OpB1),
    .Op0       (Op0),
    .Op1       (Op1),
    .Gnt0      (Gnt0),
    .Gnt1      (Gnt1),
    .RspValid0 (RspValid0),
    .RspValid1 (RspValid1),
    .Result    (Result),
    .AluA      (AluA),
    .AluB      (AluB),
    .AluOp     (AluOp),
    .AluOvIn   (AluOvIn),
    .AluOut    (AluOut),
    .AluOvOut  (AluOvOut),
    .Carry     (Carry),
    .Halted    (Halted)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    logic [8:0] sum;
    sum      = {1'b0, AluA} + {1'b0, AluB} + {8'd0, AluOvIn};
    AluOut   = 8'h00;
    AluOvOut = 1'b0;
    case (AluOp)
      OP_ADD:  begin AluOut = sum[7:0]; AluOvOut = sum[8]; end
      OP_SUB:  AluOut = AluA - AluB;
      OP_NAND: AluOut = ~(AluA & AluB);
      OP_OR:   AluOut = AluA | AluB;
      OP_LT:   AluOut = {7'd0, AluA < AluB};
      OP_EQL:  AluOut = {7'd0, AluA == AluB};
      default: AluOut = 8'h00;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  // Drives one request and returns what was observed in
  // the grant cycle and the response cycle.
  task automatic run_op(input bit port, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] op,
                        output bit g, output bit ovin,
                        output bit rsp, output bit rsp_other,
                        output logic [7:0] res, output bit cy);
    if (port) begin
      Req1 = 1'b1; OpA1 = a; OpB1 = b; Op1 = op;
    end else begin
      Req0 = 1'b1; OpA0 = a; OpB0 = b; Op0 = op;
    end
    tick();
    g    = port ? Gnt1 : Gnt0;
    ovin = AluOvIn;
    Req0 = 1'b0;
    Req1 = 1'b0;
    tick();
    rsp       = port ? RspValid1 : RspValid0;
    rsp_other = port ? RspValid0 : RspValid1;
    res       = Result;
    cy        = Carry;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({Gnt0, Gnt1, RspValid0, RspValid1, Carry, Halted} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {Gnt0, Gnt1, RspValid0, RspValid1, Carry, Halted});
    end
    checks++;
    if ({Result, AluA, AluB, AluOp} !== 28'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0",
               {Result, AluA, AluB, AluOp});
    end
  endtask

  task automatic test_single_add();
    bit g, ov, r, ro, cy;
    logic [7:0] res;
    run_op(1'b0, 8'hF0, 8'h20, OP_ADD, g, ov, r, ro, res, cy);
    checks++;
    if (g !== 1'b1) begin
      errors++; $display("FAIL add_gnt: got %b want 1", g);
    end
    checks++;
    if ({r, ro, res, cy} !== {1'b1, 1'b0, 8'h10, 1'b1}) begin
      errors++;
      $display("FAIL add_rsp: got rsp=%b other=%b res=%h cy=%b want 1 0 10 1",
               r, ro, res, cy);
    end
  endtask

  task automatic test_carry_chain();
    bit g, ov, r, ro, cy;
    logic [7:0] res;
    run_op(1'b0, 8'h01, 8'h01, OP_ADD, g, ov, r, ro, res, cy);
    checks++;
    if ({g, ov} !== 2'b11) begin
      errors++; $display("FAIL chain_ovin: got %b want 11", {g, ov});
    end
    checks++;
    if ({r, res, cy} !== {1'b1, 8'h03, 1'b0}) begin
      errors++;
      $display("FAIL chain_res: got %b %h %b want 1 03 0", r, res, cy);
    end
    run_op(1'b0, 8'hFF, 8'h01, OP_ADD, g, ov, r, ro, res, cy);
    checks++;
    if ({res, cy} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL chain_set: got %h %b want 00 1", res, cy);
    end
    run_op(1'b0, 8'h12, 8'h34, OP_RST, g, ov, r, ro, res, cy);
    checks++;
    if ({ov, r, cy} !== 3'b110) begin
      errors++; $display("FAIL chain_rst: got %b want 110", {ov, r, cy});
    end
  endtask

  task automatic test_contention();
    bit exp;
    do_reset();
    Req0 = 1'b1; OpA0 = 8'h10; OpB0 = 8'h20; Op0 = OP_ADD;
    Req1 = 1'b1; OpA1 = 8'h07; OpB1 = 8'h02; Op1 = OP_SUB;
    for (int k = 0; k < 4; k++) begin
      exp = k[0];
      tick();
      checks++;
      if ({Gnt1, Gnt0} !== (exp ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_gnt%0d: got %b want %b", k, {Gnt1, Gnt0},
                 exp ? 2'b10 : 2'b01);
      end
      tick();
      checks++;
      if ({RspValid1, RspValid0, Result} !==
          (exp ? {2'b10, 8'h05} : {2'b01, 8'h30})) begin
        errors++;
        $display("FAIL rr_rsp%0d: got %b %h", k, {RspValid1, RspValid0},
                 Result);
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
  endtask

  task automatic test_compare();
    bit g, ov, r, ro, cy;
    logic [7:0] res;
    run_op(1'b0, 8'hFF, 8'h01, OP_ADD, g, ov, r, ro, res, cy);
    run_op(1'b1, 8'h03, 8'h05, OP_LT, g, ov, r, ro, res, cy);
    checks++;
    if ({g, r, ro, res, cy} !== {3'b110, 8'h01, 1'b1}) begin
      errors++;
      $display("FAIL cmp_lt: got %b %b %b %h %b want 1 1 0 01 1",
               g, r, ro, res, cy);
    end
    run_op(1'b1, 8'hAA, 8'h55, 4'b1111, g, ov, r, ro, res, cy);
    checks++;
    if ({r, res, cy} !== {1'b1, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL undef_op: got %b %h %b want 1 00 1", r, res, cy);
    end
  endtask

  task automatic test_halt();
    Req0 = 1'b1; OpA0 = 8'h00; OpB0 = 8'h00; Op0 = OP_HALT;
    Req1 = 1'b1; OpA1 = 8'h11; OpB1 = 8'h22; Op1 = OP_ADD;
    tick();
    checks++;
    if ({Gnt0, Gnt1} !== 2'b10) begin
      errors++; $display("FAIL halt_gnt: got %b want 10", {Gnt0, Gnt1});
    end
    Req0 = 1'b0;
    tick();
    checks++;
    if ({RspValid0, Halted} !== 2'b11) begin
      errors++;
      $display("FAIL halt_rsp: got %b want 11", {RspValid0, Halted});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({Gnt1, Halted, RspValid0} !== 3'b010) begin
        errors++;
        $display("FAIL halt_hold%0d: got %b want 010", k,
                 {Gnt1, Halted, RspValid0});
      end
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (Halted !== 1'b0) begin
      errors++; $display("FAIL halt_clear: got %b want 0", Halted);
    end
    tick();
    Reset_n = 1'b1;
    tick();
    checks++;
    if ({Gnt1, Gnt0} !== 2'b10) begin
      errors++;
      $display("FAIL halt_regrant: got %b want 10", {Gnt1, Gnt0});
    end
    Req1 = 1'b0;
    tick();
    checks++;
    if ({RspValid1, Result} !== {1'b1, 8'h33}) begin
      errors++;
      $display("FAIL halt_after: got %b %h want 1 33", RspValid1, Result);
    end
  endtask

  task automatic test_async_reset();
    Req0 = 1'b1; OpA0 = 8'h55; OpB0 = 8'h0F; Op0 = OP_SUB;
    tick();
    checks++;
    if ({Gnt0, AluA, AluOp} !== {1'b1, 8'h55, OP_SUB}) begin
      errors++;
      $display("FAIL arst_exec: got %b %h %h want 1 55 1", Gnt0, AluA, AluOp);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({Gnt0, Gnt1, RspValid0, RspValid1, Result, AluA, AluB, AluOp,
         Carry, Halted} !== 34'h0) begin
      errors++;
      $display("FAIL arst_zero: got gnt=%b res=%h a=%h b=%h op=%h",
               Gnt0, Result, AluA, AluB, AluOp);
    end
    Req0 = 1'b0;
    tick();
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({RspValid0, Gnt0} !== 2'b00) begin
        errors++;
        $display("FAIL arst_norsp%0d: got %b want 00", k, {RspValid0, Gnt0});
      end
    end
  endtask

  initial begin
    Reset_n = 1'b1;
    Req0 = 1'b0; Req1 = 1'b0;
    OpA0 = '0; OpA1 = '0; OpB0 = '0; OpB1 = '0;
    Op0 = '0; Op1 = '0;
    tick();
    test_reset();
    test_single_add();
    test_carry_chain();
    test_contention();
    test_compare();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
